load_store_unit: RTL and testbench

//  MEM-stage initiator for the data memory. Takes one load/store per instruction from the pipeline,

---
 rtl/load_store_unit_pkg.sv | 29 ++
 rtl/load_store_unit_if.sv | 44 ++++
 rtl/load_store_unit_lane_align.sv | 52 +++++
 rtl/load_store_unit.sv | 144 ++++++++++++++
 tb/tb_load_store_unit.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
// Access-size encodings follow the ls_size field of the pipeline request.
package load_store_unit_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } lsu_state_t;

    // Reserved size, odd halfword, or word not on a 4-byte boundary.
    function automatic logic bad_alignment(input logic [1:0] size, input logic [1:0] lo);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_HALF: bad = lo[0];
            SZ_WORD: bad = (lo != 2'b00);
            SZ_RSVD: bad = 1'b1;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline-side and data-memory-side signals of the load/store unit.
// master = the LSU itself; slave = its environment (pipeline + data memory).
interface load_store_unit_if #(
    parameter int ADDR_W = 32
);
    // Pipeline side: ls_valid is held stable while stall=1; the request is
    // consumed on the edge where stall=0 (result then reported by ld_valid).
    logic              ls_valid;
    logic              ls_read;
    logic              ls_write;
    logic [1:0]        ls_size;
    logic              ls_unsigned;
    logic [ADDR_W-1:0] ls_addr;
    logic [31:0]       ls_wdata;
    logic              stall;
    logic              ld_valid;
    logic [31:0]       ld_data;
    logic              addr_err;
    logic              bus_err;
    // Memory side: mem_req with its qualifiers stays stable until the cycle
    // mem_ack is seen (or the timeout expires); read data is valid with mem_ack.
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport master (
        input  ls_valid, ls_read, ls_write, ls_size, ls_unsigned, ls_addr, ls_wdata,
        input  mem_ack, mem_rdata,
        output stall, ld_valid, ld_data, addr_err, bus_err,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport slave (
        output ls_valid, ls_read, ls_write, ls_size, ls_unsigned, ls_addr, ls_wdata,
        output mem_ack, mem_rdata,
        input  stall, ld_valid, ld_data, addr_err, bus_err,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

endinterface

// File: rtl/load_store_unit_lane_align.sv
// Byte-lane steering: store replication and byte enables, load extract/extend.
// Purely combinational; lanes are little-endian with lane = addr[1:0].
module load_store_unit_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [1:0]  st_size_i,
    input  logic [1:0]  st_lane_i,
    input  logic [31:0] st_data_i,
    output logic [3:0]  st_be_o,
    output logic [31:0] st_wdata_o,
    input  logic [1:0]  ld_size_i,
    input  logic [1:0]  ld_lane_i,
    input  logic        ld_unsigned_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_data_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_be_o    = 4'b0000;
        st_wdata_o = st_data_i;
        case (st_size_i)
            SZ_BYTE: begin
                st_be_o    = 4'b0001 << st_lane_i;
                st_wdata_o = {4{st_data_i[7:0]}};
            end
            SZ_HALF: begin
                st_be_o    = 4'b0011 << {st_lane_i[1], 1'b0};
                st_wdata_o = {2{st_data_i[15:0]}};
            end
            SZ_WORD: st_be_o = 4'b1111;
            default: st_be_o = 4'b0000;
        endcase
    end

    assign ld_byte = ld_rdata_i[{ld_lane_i, 3'b000} +: 8];
    assign ld_half = ld_rdata_i[{ld_lane_i[1], 4'b0000} +: 16];

    always_comb begin
        ld_data_o = ld_rdata_i;
        case (ld_size_i)
            SZ_BYTE: ld_data_o = ld_unsigned_i ? {24'h0, ld_byte}
                                               : {{24{ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_data_o = ld_unsigned_i ? {16'h0, ld_half}
                                               : {{16{ld_half[15]}}, ld_half};
            default: ld_data_o = ld_rdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: accepts one access, runs req/ack to data memory
// with a timeout, and reports extended load data plus error flags for one cycle.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    load_store_unit_if.master  bus,
    output lsu_state_t         state_o
);

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [1:0]        lane_q, lane_d;
    logic [31:0]       data_q, data_d;
    logic              aerr_q, aerr_d;
    logic              berr_q, berr_d;

    logic        accept;
    logic        illegal;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] ld_ext;

    assign accept  = bus.ls_valid & (bus.ls_read | bus.ls_write);
    assign illegal = (bus.ls_read & bus.ls_write) | bad_alignment(bus.ls_size, bus.ls_addr[1:0]);

    // Store lanes come from the live request; load extraction uses the captured one.
    load_store_unit_lane_align u_align (
        .st_size_i     (bus.ls_size),
        .st_lane_i     (bus.ls_addr[1:0]),
        .st_data_i     (bus.ls_wdata),
        .st_be_o       (st_be),
        .st_wdata_o    (st_wdata),
        .ld_size_i     (size_q),
        .ld_lane_i     (lane_q),
        .ld_unsigned_i (uns_q),
        .ld_rdata_i    (bus.mem_rdata),
        .ld_data_o     (ld_ext)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= 4'b0000;
            wdata_q <= 32'h0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            lane_q  <= 2'b00;
            data_q  <= 32'h0;
            aerr_q  <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            lane_q  <= lane_d;
            data_q  <= data_d;
            aerr_q  <= aerr_d;
            berr_q  <= berr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        uns_d   = uns_q;
        lane_d  = lane_q;
        data_d  = data_q;
        aerr_d  = aerr_q;
        berr_d  = berr_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d    = bus.ls_write;
                    addr_d  = {bus.ls_addr[ADDR_W-1:2], 2'b00};
                    be_d    = st_be;
                    wdata_d = bus.ls_write ? st_wdata : 32'h0;
                    size_d  = bus.ls_size;
                    uns_d   = bus.ls_unsigned;
                    lane_d  = bus.ls_addr[1:0];
                    data_d  = 32'h0;
                    aerr_d  = illegal;
                    berr_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = illegal ? DONE : REQ;
                end
            end
            REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                // An ack on the final allowed cycle still completes normally.
                if (bus.mem_ack) begin
                    data_d  = we_q ? 32'h0 : ld_ext;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    data_d  = 32'h0;
                    berr_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Gating stall with reset_n keeps it low while reset holds an accepting request.
    assign bus.stall     = reset_n & (((state_q == IDLE) & accept) | (state_q == REQ));
    assign bus.mem_req   = (state_q == REQ);
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_be    = be_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.ld_valid  = (state_q == DONE);
    assign bus.ld_data   = (state_q == DONE) ? data_q : 32'h0;
    assign bus.addr_err  = (state_q == DONE) & aerr_q;
    assign bus.bus_err   = (state_q == DONE) & berr_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a vector table of single accesses with
// hand-computed results, plus sequences for reset, idle and mid-request reset.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    localparam int TIMEOUT = 16;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_at;
        int          exp_req;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_data;
        logic        exp_aerr;
        logic        exp_berr;
    } vec_t;

    logic       clock;
    logic       reset_n;
    lsu_state_t state;
    int         checks;
    int         failures;
    vec_t       vecs[17];

    load_store_unit_if #(.ADDR_W(32)) bus ();

    load_store_unit #(.ADDR_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus),
        .state_o (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [1:0] size,
                                input logic uns, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                input int ack_at, input int exp_req, input logic [3:0] exp_be,
                                input logic [31:0] exp_wdata, input logic [31:0] exp_data,
                                input logic exp_aerr, input logic exp_berr);
        vec_t v;
        v.rd = rd; v.wr = wr; v.size = size; v.uns = uns; v.addr = addr;
        v.wdata = wdata; v.rdata = rdata; v.ack_at = ack_at; v.exp_req = exp_req;
        v.exp_be = exp_be; v.exp_wdata = exp_wdata; v.exp_data = exp_data;
        v.exp_aerr = exp_aerr; v.exp_berr = exp_berr;
        return v;
    endfunction

    task automatic idle_inputs();
        bus.ls_valid = 1'b0; bus.ls_read = 1'b0; bus.ls_write = 1'b0;
        bus.ls_size = 2'b00; bus.ls_unsigned = 1'b0; bus.ls_addr = 32'h0;
        bus.ls_wdata = 32'h0; bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
    endtask

    // Present one access; ack is raised during REQ cycle ack_at (1-based, 0 = never).
    task automatic run_vec(input vec_t v, input int idx);
        int         req_n, stall_n;
        bit         seen, done;
        logic [3:0] be_c;
        logic       we_c;
        logic [31:0] addr_c, wd_c;
        string      tag;
        tag = $sformatf("v%0d", idx);
        req_n = 0; stall_n = 0; seen = 0; done = 0;
        be_c = 4'h0; we_c = 1'b0; addr_c = 32'h0; wd_c = 32'h0;
        @(posedge clock); #1;
        bus.ls_valid = 1'b1; bus.ls_read = v.rd; bus.ls_write = v.wr;
        bus.ls_size = v.size; bus.ls_unsigned = v.uns; bus.ls_addr = v.addr;
        bus.ls_wdata = v.wdata; bus.mem_rdata = v.rdata; bus.mem_ack = 1'b0;
        for (int cyc = 0; cyc < TIMEOUT + 6 && !done; cyc++) begin
            if (cyc > 0) begin
                @(posedge clock); #1;
                bus.mem_ack = (v.ack_at != 0) && (cyc == v.ack_at);
            end
            @(negedge clock);
            if (bus.ld_valid) begin
                done = 1;
                check({tag, " ld_data"}, bus.ld_data, v.exp_data);
                check({tag, " addr_err"}, 32'(bus.addr_err), 32'(v.exp_aerr));
                check({tag, " bus_err"}, 32'(bus.bus_err), 32'(v.exp_berr));
                check({tag, " stall_in_done"}, 32'(bus.stall), 32'd0);
            end else begin
                if (bus.stall) stall_n++;
                if (bus.mem_req) begin
                    req_n++;
                    if (!seen) begin
                        seen = 1; be_c = bus.mem_be; we_c = bus.mem_we;
                        addr_c = bus.mem_addr; wd_c = bus.mem_wdata;
                    end
                end
            end
        end
        check({tag, " completed"}, 32'(done), 32'd1);
        check({tag, " req_cycles"}, 32'(req_n), 32'(v.exp_req));
        check({tag, " stall_cycles"}, 32'(stall_n), 32'(v.exp_req + 1));
        if (v.exp_req > 0) begin
            check({tag, " mem_be"}, 32'(be_c), 32'(v.exp_be));
            check({tag, " mem_we"}, 32'(we_c), 32'(v.wr));
            check({tag, " mem_addr"}, addr_c, v.addr & 32'hFFFF_FFFC);
            if (v.wr) check({tag, " mem_wdata"}, wd_c, v.exp_wdata);
        end
        @(posedge clock); #1;
        idle_inputs();
        @(negedge clock);
        check({tag, " ld_valid_pulse"}, 32'(bus.ld_valid), 32'd0);
    endtask

    initial begin
        int pulses;
        checks = 0;
        failures = 0;
        idle_inputs();
        reset_n = 1'b0;

        vecs[0]  = mk(0, 1, SZ_WORD, 0, 32'h8, 32'hDEADBEEF, 32'h0, 3, 3, 4'b1111, 32'hDEADBEEF, 32'h0, 0, 0);
        vecs[1]  = mk(1, 0, SZ_BYTE, 0, 32'h5, 32'h0, 32'h0000_8000, 1, 1, 4'b0010, 32'h0, 32'hFFFF_FF80, 0, 0);
        vecs[2]  = mk(1, 0, SZ_BYTE, 1, 32'h5, 32'h0, 32'h0000_8000, 1, 1, 4'b0010, 32'h0, 32'h0000_0080, 0, 0);
        vecs[3]  = mk(0, 1, SZ_HALF, 0, 32'h6, 32'hABCD_1234, 32'h0, 2, 2, 4'b1100, 32'h1234_1234, 32'h0, 0, 0);
        vecs[4]  = mk(1, 0, SZ_HALF, 0, 32'h6, 32'h0, 32'h8001_0000, 1, 1, 4'b1100, 32'h0, 32'hFFFF_8001, 0, 0);
        vecs[5]  = mk(1, 0, SZ_HALF, 1, 32'h6, 32'h0, 32'h8001_0000, 1, 1, 4'b1100, 32'h0, 32'h0000_8001, 0, 0);
        vecs[6]  = mk(1, 0, SZ_WORD, 0, 32'h2, 32'h0, 32'h5555_5555, 1, 0, 4'b0000, 32'h0, 32'h0, 1, 0);
        vecs[7]  = mk(1, 1, SZ_WORD, 0, 32'h0, 32'h0, 32'h5555_5555, 1, 0, 4'b0000, 32'h0, 32'h0, 1, 0);
        vecs[8]  = mk(1, 0, SZ_RSVD, 0, 32'h0, 32'h0, 32'h5555_5555, 1, 0, 4'b0000, 32'h0, 32'h0, 1, 0);
        vecs[9]  = mk(1, 0, SZ_HALF, 0, 32'h1, 32'h0, 32'h5555_5555, 1, 0, 4'b0000, 32'h0, 32'h0, 1, 0);
        vecs[10] = mk(1, 0, SZ_WORD, 0, 32'h100, 32'h0, 32'h1111_1111, 0, 16, 4'b1111, 32'h0, 32'h0, 0, 1);
        vecs[11] = mk(1, 0, SZ_WORD, 0, 32'h104, 32'h0, 32'h1234_5678, 16, 16, 4'b1111, 32'h0, 32'h1234_5678, 0, 0);
        vecs[12] = mk(0, 1, SZ_BYTE, 0, 32'h7, 32'h0000_00A5, 32'h0, 1, 1, 4'b1000, 32'hA5A5_A5A5, 32'h0, 0, 0);
        vecs[13] = mk(1, 0, SZ_BYTE, 0, 32'h3, 32'h0, 32'h7F00_0000, 2, 2, 4'b1000, 32'h0, 32'h0000_007F, 0, 0);
        vecs[14] = mk(1, 0, SZ_BYTE, 0, 32'h2, 32'h0, 32'h00F0_0000, 1, 1, 4'b0100, 32'h0, 32'hFFFF_FFF0, 0, 0);
        vecs[15] = mk(1, 0, SZ_HALF, 0, 32'h0, 32'h0, 32'h0000_FFFE, 1, 1, 4'b0011, 32'h0, 32'hFFFF_FFFE, 0, 0);
        vecs[16] = mk(0, 1, SZ_HALF, 0, 32'h3, 32'h0000_BEEF, 32'h0, 1, 0, 4'b0000, 32'h0, 32'h0, 1, 0);

        // Reset values
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst stall", 32'(bus.stall), 32'd0);
        check("rst mem_req", 32'(bus.mem_req), 32'd0);
        check("rst ld_valid", 32'(bus.ld_valid), 32'd0);
        check("rst ld_data", bus.ld_data, 32'h0);
        check("rst errs", {30'h0, bus.addr_err, bus.bus_err}, 32'h0);
        check("rst mem_bus", {27'h0, bus.mem_we, bus.mem_be}, 32'h0);
        check("rst mem_addr", bus.mem_addr, 32'h0);
        check("rst mem_wdata", bus.mem_wdata, 32'h0);
        check("rst state", 32'(state), 32'(IDLE));
        @(posedge clock); #1;
        reset_n = 1'b1;

        // Idle: no valid, valid without read/write, and stray acks do nothing
        @(posedge clock); #1;
        bus.mem_ack = 1'b1;
        @(negedge clock);
        check("idle stall", 32'(bus.stall), 32'd0);
        @(posedge clock); #1;
        bus.ls_valid = 1'b1;
        @(negedge clock);
        check("noop stall", 32'(bus.stall), 32'd0);
        @(posedge clock); #1;
        @(negedge clock);
        check("noop mem_req", 32'(bus.mem_req), 32'd0);
        check("noop ld_valid", 32'(bus.ld_valid), 32'd0);
        check("noop state", 32'(state), 32'(IDLE));
        idle_inputs();

        for (int i = 0; i < 17; i++) run_vec(vecs[i], i);

        // Reset in the middle of a request abandons it
        @(posedge clock); #1;
        bus.ls_valid = 1'b1; bus.ls_read = 1'b1; bus.ls_size = SZ_WORD; bus.ls_addr = 32'h40;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("midreq mem_req_before", 32'(bus.mem_req), 32'd1);
        @(posedge clock); #2;
        reset_n = 1'b0;
        #1;
        check("midreq mem_req", 32'(bus.mem_req), 32'd0);
        check("midreq stall", 32'(bus.stall), 32'd0);
        check("midreq state", 32'(state), 32'(IDLE));
        idle_inputs();
        @(posedge clock); #1;
        reset_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            if (bus.ld_valid) pulses++;
        end
        check("midreq no_ld_valid", 32'(pulses), 32'd0);
        run_vec(mk(1, 0, SZ_WORD, 0, 32'h0, 32'h0, 32'hCAFE_F00D, 2, 2, 4'b1111, 32'h0, 32'hCAFE_F00D, 0, 0), 99);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
